// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between NUM_REQ
// requesters. Each operation walks IDLE -> EXEC -> RESP. The response is
// held until the consumer takes it.
module alu_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]   req_ctrl,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_illegal,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ctrl;
  } op_t;

  // The flat request buses have the same bit layout as these packed arrays.
  logic [NUM_REQ-1:0][7:0] a_arr, b_arr;
  logic [NUM_REQ-1:0][3:0] c_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;
  assign c_arr = req_ctrl;

  state_t          state;
  op_t             op;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic            any_vld;

  function automatic logic illegal_op(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: illegal_op = 1'b0;
      default:                                              illegal_op = 1'b1;
    endcase
  endfunction

  // Round-robin pick. The loop runs from farthest to nearest so that the
  // valid requester closest to rr_ptr is the last one written and wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    any_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        gnt     = ID_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  // Accept is one-hot on the winner, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_vld) req_ready[gnt] = 1'b1;
  end

  // The ALU always sees the latched operands, never the live request buses.
  assign alu_a    = op.a;
  assign alu_b    = op.b;
  assign alu_ctrl = op.ctrl;
  assign busy     = (state != IDLE);

  // Arbitration FSM. It owns the operand, response and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op          <= '0;
      id_reg      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_vld) begin
          op.a    <= a_arr[gnt];
          op.b    <= b_arr[gnt];
          op.ctrl <= c_arr[gnt];
          id_reg  <= gnt;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_result  <= alu_result;
          rsp_zero    <= alu_zero;
          rsp_illegal <= illegal_op(op.ctrl);
          rsp_id      <= id_reg;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. A behavioural ALU drives the DUT's ALU port. A
// transaction-level model checks each grant, the operands the DUT issues,
// and the response. The model tracks a round-robin pointer, requester
// valid flags and an arithmetic reference.
module tb_alu_arbiter;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready;
  logic [8*N-1:0]    req_a, req_b;
  logic [4*N-1:0]    req_ctrl;
  logic [7:0]        alu_a, alu_b;
  logic [3:0]        alu_ctrl;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_illegal, busy;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // requester-side state
  logic [N-1:0] vmask;
  logic [7:0]   oa [N];
  logic [7:0]   ob [N];
  logic [3:0]   oc [N];
  int           ptr;
  int           vecs, errs;
  int           cyc;
  int           gc, last_gc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
    logic [31:0] x, y;
    x = {24'd0, a};
    y = {24'd0, b};
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic legal(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  // behavioural ALU attached to the DUT
  always_comb begin
    alu_result = alu_ref(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  // pack requester state onto the flat buses
  always_comb begin
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8]    = oa[i];
      req_b[8*i +: 8]    = ob[i];
      req_ctrl[4*i +: 4] = oc[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (vmask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic rand_ops(input int i);
    logic [3:0] legal_ops [6];
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    oa[i] = 8'($urandom);
    ob[i] = 8'($urandom);
    oc[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
  endtask

  // One full operation. after: 0 = requester drops, 1 = keeps valid with new
  // operands, 2 = random choice.
  task automatic txn(input int hold, input int after);
    int          g, w;
    logic [7:0]  ea, eb;
    logic [3:0]  ec;
    logic [31:0] er;
    g = winner();
    if (g < 0) return;
    w = 0;
    while (req_ready == '0 && w < 20) begin
      tick();
      w++;
    end
    if (req_ready == '0) begin
      check("grant_timeout", 32'(req_ready), 32'(1 << g));
      return;
    end
    check("gnt", 32'(req_ready), 32'(1 << g));
    check("busy_idle", 32'(busy), 0);
    check("rspv_idle", 32'(rsp_valid), 0);
    ea = oa[g]; eb = ob[g]; ec = oc[g];
    er = alu_ref(ea, eb, ec);
    gc = cyc;
    rsp_ready = (hold == 0);
    tick();  // grant edge
    // scramble the granted requester; the DUT must already hold its copy
    rand_ops(g);
    if (after == 0) vmask[g] = 1'b0;
    else if (after == 2) vmask[g] = 1'($urandom);
    #1;
    check("busy_exec", 32'(busy), 1);
    check("rdy_exec", 32'(req_ready), 0);
    check("rspv_exec", 32'(rsp_valid), 0);
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(eb));
    check("alu_ctrl", 32'(alu_ctrl), 32'(ec));
    tick();  // EXEC edge
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_id", 32'(rsp_id), 32'(g));
      check("rsp_result", rsp_result, er);
      check("rsp_zero", 32'(rsp_zero), 32'(er == 0));
      check("rsp_illegal", 32'(rsp_illegal), 32'(!legal(ec)));
      check("rdy_resp", 32'(req_ready), 0);
      if (h == hold) rsp_ready = 1'b1;
      tick();
    end
    check("rspv_done", 32'(rsp_valid), 0);
    check("busy_done", 32'(busy), 0);
    ptr = (g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = 0; errs = 0; cyc = 0; ptr = 0;
    vmask = '0; rsp_ready = 1'b0; reset = 1'b1;
    for (int i = 0; i < N; i++) begin oa[i] = '0; ob[i] = '0; oc[i] = '0; end
    tick(); tick();
    reset = 1'b0;
    // idle after reset with nobody requesting
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst_ready", 32'(req_ready), 0);
      check("rst_rspv", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ctrl", 32'(alu_ctrl), 0);
      check("rst_result", rsp_result, 0);
      tick();
    end

    // directed operations
    oa[0] = 8'h03; ob[0] = 8'h05; oc[0] = 4'b0110; vmask = 4'b0001; #1;
    txn(0, 0);
    oa[2] = 8'hFF; ob[2] = 8'h01; oc[2] = 4'b0010; vmask = 4'b0100; #1;
    txn(0, 0);
    oa[2] = 8'h0F; ob[2] = 8'hF0; oc[2] = 4'b0000; vmask = 4'b0100; #1;
    txn(0, 0);
    oa[1] = 8'h12; ob[1] = 8'h34; oc[1] = 4'b1010; vmask = 4'b0010; #1;
    txn(5, 0);

    // every requester valid continuously after a fresh reset
    reset = 1'b1; tick(); reset = 1'b0; ptr = 0;
    for (int i = 0; i < N; i++) rand_ops(i);
    vmask = '1; #1;
    last_gc = -1;
    for (int t = 0; t < 8; t++) begin
      txn(0, 1);
      if (last_gc >= 0) check("grant_spacing", 32'(gc - last_gc), 3);
      last_gc = gc;
    end

    // reset during EXEC drops the operation and restarts the pointer at 0
    vmask = 4'b0010; #1;
    txn(0, 0);                         // ptr -> 2
    rand_ops(1); rand_ops(3);
    vmask = 4'b1010; #1;
    check("pre_rst_gnt", 32'(req_ready), 32'(1 << winner()));
    tick();                            // grant edge, now in EXEC
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("rst_exec_busy", 32'(busy), 0);
    check("rst_exec_rspv", 32'(rsp_valid), 0);
    ptr = 0;
    txn(0, 0);                         // requester 1 wins from pointer 0
    txn(0, 0);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++)
        if (!vmask[i] && $urandom_range(0, 2) == 0) begin
          rand_ops(i);
          vmask[i] = 1'b1;
        end
      if (vmask == '0) begin
        rand_ops(t % N);
        vmask[t % N] = 1'b1;
      end
      #1;
      txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
